// File: rtl/cam_lookup_ctrl.sv
// Front-end controller for the CAM: allocates free slots on store, runs one seek at a time, and frees the entry on a hit.
// Latency: seek accept -> rsp valid in 2 cycles; stores complete in 1 cycle; backpressure via I_Rsp_Ready (held in RESP, no accepts).
module cam_lookup_ctrl #(
    parameter int LENGTH     = 16,
    parameter int WIDTH_DATA = 32
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          I_St_Valid,
    input  logic [WIDTH_DATA-1:0]         I_St_Data,
    output logic                          O_St_Ready,
    input  logic                          I_Sk_Valid,
    input  logic [WIDTH_DATA-1:0]         I_Sk_Data,
    output logic                          O_Sk_Ready,
    output logic                          O_Rsp_Valid,
    output logic                          O_Rsp_Hit,
    output logic [WIDTH_DATA-1:0]         O_Rsp_Data,
    output logic [$clog2(LENGTH)-1:0]     O_Rsp_Index,
    input  logic                          I_Rsp_Ready,
    output logic                          O_We,
    output logic [$clog2(LENGTH)-1:0]     O_Addr,
    output logic [WIDTH_DATA-1:0]         O_Data,
    output logic                          O_Seek,
    output logic [WIDTH_DATA-1:0]         O_CData,
    output logic [$clog2(LENGTH)-1:0]     O_Sel,
    input  logic                          I_Hit,
    input  logic [WIDTH_DATA-1:0]         I_Data,
    input  logic [LENGTH-1:0]             I_Valid,
    output logic [$clog2(LENGTH+1)-1:0]   O_Count,
    output logic                          O_Full,
    output logic                          O_Empty
);
    localparam int AW = $clog2(LENGTH);
    localparam int CW = $clog2(LENGTH + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEEK = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [LENGTH-1:0]     occ_q, occ_d;
    logic [CW-1:0]         count_q, count_d;
    logic [WIDTH_DATA-1:0] key_q, key_d;
    logic                  rsp_hit_q, rsp_hit_d;
    logic [WIDTH_DATA-1:0] rsp_data_q, rsp_data_d;
    logic [AW-1:0]         rsp_idx_q, rsp_idx_d;

    logic          idle;
    logic          seeking;
    logic          st_acc;
    logic          sk_acc;
    logic [AW-1:0] free_idx;
    logic [AW-1:0] sel_idx;

    // Lowest-index priority encoders; scanning downward lets the lowest index win.
    always_comb begin
        free_idx = '0;
        for (int i = LENGTH - 1; i >= 0; i--) begin
            if (!occ_q[i]) free_idx = AW'(i);
        end
    end

    always_comb begin
        sel_idx = '0;
        for (int i = LENGTH - 1; i >= 0; i--) begin
            if (I_Valid[i]) sel_idx = AW'(i);
        end
    end

    // Outputs are gated with reset so the port state is quiet while reset is held.
    assign idle        = (state_q == ST_IDLE) & ~reset;
    assign seeking     = (state_q == ST_SEEK) & ~reset;
    assign O_Full      = (count_q == CW'(LENGTH));
    assign O_Empty     = (count_q == '0);
    assign O_Count     = count_q;
    assign O_Sk_Ready  = idle;
    assign O_St_Ready  = idle & ~O_Full & ~I_Sk_Valid;
    assign sk_acc      = idle & I_Sk_Valid;
    assign st_acc      = O_St_Ready & I_St_Valid;
    assign O_We        = st_acc;
    assign O_Addr      = st_acc ? free_idx : '0;
    assign O_Data      = st_acc ? I_St_Data : '0;
    assign O_Seek      = seeking;
    assign O_CData     = seeking ? key_q : '0;
    assign O_Sel       = seeking ? sel_idx : '0;
    assign O_Rsp_Valid = (state_q == ST_RESP) & ~reset;
    assign O_Rsp_Hit   = rsp_hit_q;
    assign O_Rsp_Data  = rsp_data_q;
    assign O_Rsp_Index = rsp_idx_q;

    always_comb begin
        state_d    = state_q;
        occ_d      = occ_q;
        count_d    = count_q;
        key_d      = key_q;
        rsp_hit_d  = rsp_hit_q;
        rsp_data_d = rsp_data_q;
        rsp_idx_d  = rsp_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (sk_acc) begin
                    key_d   = I_Sk_Data;
                    state_d = ST_SEEK;
                end else if (st_acc) begin
                    occ_d[free_idx] = 1'b1;
                    count_d         = count_q + CW'(1);
                end
            end
            ST_SEEK: begin
                state_d = ST_RESP;
                if (I_Hit) begin
                    rsp_hit_d      = 1'b1;
                    rsp_data_d     = I_Data;
                    rsp_idx_d      = sel_idx;
                    occ_d[sel_idx] = 1'b0;
                    count_d        = count_q - CW'(1);
                end else begin
                    rsp_hit_d  = 1'b0;
                    rsp_data_d = '0;
                    rsp_idx_d  = '0;
                end
            end
            ST_RESP: begin
                if (I_Rsp_Ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            occ_q      <= '0;
            count_q    <= '0;
            key_q      <= '0;
            rsp_hit_q  <= 1'b0;
            rsp_data_q <= '0;
            rsp_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            occ_q      <= occ_d;
            count_q    <= count_d;
            key_q      <= key_d;
            rsp_hit_q  <= rsp_hit_d;
            rsp_data_q <= rsp_data_d;
            rsp_idx_q  <= rsp_idx_d;
        end
    end
endmodule

// File: tb/tb_cam_lookup_ctrl.sv
// Bench for cam_lookup_ctrl with a simple CAM behind it and a slot-list reference model.
module tb_cam_lookup_ctrl;
    localparam int L = 16;
    localparam int W = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic          I_St_Valid, I_Sk_Valid, I_Rsp_Ready;
    logic [W-1:0]  I_St_Data, I_Sk_Data;
    logic          O_St_Ready, O_Sk_Ready, O_Rsp_Valid, O_Rsp_Hit;
    logic [W-1:0]  O_Rsp_Data, O_Data, O_CData;
    logic [3:0]    O_Rsp_Index, O_Addr, O_Sel;
    logic          O_We, O_Seek, I_Hit, O_Full, O_Empty;
    logic [W-1:0]  I_Data;
    logic [L-1:0]  I_Valid;
    logic [4:0]    O_Count;

    cam_lookup_ctrl #(.LENGTH(L), .WIDTH_DATA(W)) dut (
        .clock(clock), .reset(reset),
        .I_St_Valid(I_St_Valid), .I_St_Data(I_St_Data), .O_St_Ready(O_St_Ready),
        .I_Sk_Valid(I_Sk_Valid), .I_Sk_Data(I_Sk_Data), .O_Sk_Ready(O_Sk_Ready),
        .O_Rsp_Valid(O_Rsp_Valid), .O_Rsp_Hit(O_Rsp_Hit), .O_Rsp_Data(O_Rsp_Data),
        .O_Rsp_Index(O_Rsp_Index), .I_Rsp_Ready(I_Rsp_Ready),
        .O_We(O_We), .O_Addr(O_Addr), .O_Data(O_Data),
        .O_Seek(O_Seek), .O_CData(O_CData), .O_Sel(O_Sel),
        .I_Hit(I_Hit), .I_Data(I_Data), .I_Valid(I_Valid),
        .O_Count(O_Count), .O_Full(O_Full), .O_Empty(O_Empty)
    );

    always #5 clock = ~clock;

    // Attached CAM: stored words, valid flags, combinational match vector.
    logic [W-1:0] cam_d [L];
    logic [L-1:0] cam_v;
    always_comb begin
        I_Valid = '0;
        for (int i = 0; i < L; i++) I_Valid[i] = O_Seek && cam_v[i] && (cam_d[i] == O_CData);
    end
    assign I_Hit  = |I_Valid;
    assign I_Data = cam_d[O_Sel];
    always @(posedge clock) begin
        if (reset) begin
            cam_v <= '0;
            for (int i = 0; i < L; i++) cam_d[i] <= '0;
        end else begin
            if (O_We) begin
                cam_d[O_Addr] <= O_Data;
                cam_v[O_Addr] <= 1'b1;
            end
            if (O_Seek && I_Hit) cam_v[O_Sel] <= 1'b0;
        end
    end

    // Reference model: list of slots, each either free or holding a word.
    bit           m_occ [L];
    logic [W-1:0] m_data [L];
    int           m_cnt;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        else n_pass++;
    endtask

    function automatic void m_clear();
        for (int i = 0; i < L; i++) m_occ[i] = 0;
        m_cnt = 0;
    endfunction

    function automatic int m_free();
        for (int i = 0; i < L; i++) if (!m_occ[i]) return i;
        return -1;
    endfunction

    function automatic int m_find(input logic [W-1:0] key);
        for (int i = 0; i < L; i++) if (m_occ[i] && m_data[i] == key) return i;
        return -1;
    endfunction

    task automatic do_reset();
        reset = 1'b1; I_St_Valid = 1'b0; I_Sk_Valid = 1'b0; I_Rsp_Ready = 1'b0;
        @(negedge clock); #1;
        chk("rst_sk_rdy", O_Sk_Ready, 0);
        chk("rst_st_rdy", O_St_Ready, 0);
        chk("rst_rsp_vld", O_Rsp_Valid, 0);
        chk("rst_we_seek", {O_We, O_Seek}, 0);
        chk("rst_sel_addr", {O_Sel, O_Addr}, 0);
        chk("rst_rsp_fields", {O_Rsp_Hit, O_Rsp_Data, O_Rsp_Index}, 0);
        chk("rst_count", O_Count, 0);
        chk("rst_empty", O_Empty, 1);
        @(negedge clock);
        reset = 1'b0;
        m_clear();
        #1;
        chk("post_rst_sk_rdy", O_Sk_Ready, 1);
        chk("post_rst_st_rdy", O_St_Ready, 1);
    endtask

    // Presents one store for one cycle; the valid is left high for back-to-back use.
    task automatic store(input logic [W-1:0] d);
        int idx;
        I_Sk_Valid = 1'b0; I_St_Valid = 1'b1; I_St_Data = d;
        #1;
        idx = m_free();
        chk("st_rdy", O_St_Ready, idx >= 0);
        chk("st_we", O_We, idx >= 0);
        if (idx >= 0) begin
            chk("st_addr", O_Addr, idx);
            chk("st_data", O_Data, d);
        end
        @(negedge clock);
        if (idx >= 0) begin
            m_occ[idx] = 1; m_data[idx] = d; m_cnt++;
        end
        chk("st_count", O_Count, m_cnt);
        chk("st_full", O_Full, m_cnt == L);
        chk("st_empty", O_Empty, m_cnt == 0);
    endtask

    task automatic seek(input logic [W-1:0] key, input int hold, input bit with_st);
        int idx;
        I_Sk_Valid = 1'b1; I_Sk_Data = key; I_St_Valid = with_st; I_St_Data = 32'h5555_0000;
        I_Rsp_Ready = 1'b0;
        #1;
        chk("sk_rdy", O_Sk_Ready, 1);
        chk("sk_st_stall", {O_St_Ready, O_We}, 0);
        idx = m_find(key);
        @(negedge clock);
        I_Sk_Valid = 1'b0;
        #1;
        chk("seek_phase", {O_Seek, O_We, O_Rsp_Valid}, 3'b100);
        chk("seek_cdata", O_CData, key);
        chk("seek_sel", O_Sel, (idx >= 0) ? idx : 0);
        if (idx >= 0) begin
            m_occ[idx] = 0; m_cnt--;
        end
        @(negedge clock); #1;
        for (int h = 0; h <= hold; h++) begin
            chk("rsp_vld", O_Rsp_Valid, 1);
            chk("rsp_hit", O_Rsp_Hit, idx >= 0);
            chk("rsp_data", O_Rsp_Data, (idx >= 0) ? key : 0);
            chk("rsp_idx", O_Rsp_Index, (idx >= 0) ? idx : 0);
            chk("rsp_count", O_Count, m_cnt);
            chk("rsp_quiet", {O_We, O_Seek, O_St_Ready, O_Sk_Ready}, 0);
            if (h == hold) I_Rsp_Ready = 1'b1;
            @(negedge clock); #1;
        end
        I_Rsp_Ready = 1'b0; I_St_Valid = 1'b0;
        chk("rsp_done", O_Rsp_Valid, 0);
        chk("rsp_idle_rdy", O_Sk_Ready, 1);
    endtask

    // Reset lands while the seek is in SEEK (phase 0) or RESP (phase 1).
    task automatic reset_mid(input int phase);
        I_Sk_Valid = 1'b1; I_Sk_Data = 32'h77; I_St_Valid = 1'b0; I_Rsp_Ready = 1'b0;
        @(negedge clock);
        I_Sk_Valid = 1'b0;
        if (phase == 1) @(negedge clock);
        #1;
        chk("mid_rsp_vld_pre", O_Rsp_Valid, phase == 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        m_clear();
        #1;
        chk("mid_rsp_vld", O_Rsp_Valid, 0);
        chk("mid_count", O_Count, 0);
        chk("mid_empty", O_Empty, 1);
        chk("mid_idle", O_Sk_Ready, 1);
    endtask

    initial begin
        reset = 1'b1; I_St_Valid = 1'b0; I_Sk_Valid = 1'b0; I_Rsp_Ready = 1'b0;
        I_St_Data = '0; I_Sk_Data = '0;
        m_clear();
        do_reset();

        for (int i = 0; i < L; i++) store(32'h100 + i);
        store(32'h999);
        I_St_Valid = 1'b0;
        seek(32'h105, 0, 0);
        store(32'h200);
        I_St_Valid = 1'b0;
        seek(32'hDEAD, 0, 0);

        do_reset();
        seek(32'hDEAD, 0, 0);
        store(32'h1); store(32'h2); store(32'hAA); store(32'hAA);
        I_St_Valid = 1'b0;
        seek(32'hAA, 0, 0);
        seek(32'hAA, 0, 0);
        seek(32'hAA, 0, 0);
        seek(32'h2, 5, 1);

        store(32'h77); I_St_Valid = 1'b0;
        reset_mid(0);
        seek(32'h77, 0, 0);
        store(32'h77); I_St_Valid = 1'b0;
        reset_mid(1);
        seek(32'h77, 0, 0);

        for (int it = 0; it < 400; it++) begin
            int r;
            r = $urandom_range(0, 39);
            if (r < 22) store(32'h40 + $urandom_range(0, 5));
            else if (r < 38) seek(32'h40 + $urandom_range(0, 6), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            else if (r == 38) begin
                I_St_Valid = 1'b0;
                @(negedge clock);
            end else do_reset();
        end
        I_St_Valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
